// File: rtl/age_issue_queue_mwb.sv
// Age-matrix issue queue: oldest-ready select, multi-channel wakeup with
// enqueue bypass, robid-based flush of younger entries and occupancy count.
module age_issue_queue_mwb #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 248,
  parameter int unsigned COND_W    = 2,
  parameter int unsigned ROBID_W   = 7,
  parameter int unsigned ROBID_LSB = 241,
  parameter int unsigned WB_PORTS  = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic [DATA_W-1:0]             enq_data,
  input  logic [COND_W-1:0]             enq_condition,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [DATA_W-1:0]             deq_data,
  output logic [$clog2(DEPTH)-1:0]      deq_index,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*ROBID_W-1:0]   wb_robid,
  input  logic [WB_PORTS*COND_W-1:0]    wb_mask,
  input  logic [WB_PORTS*COND_W-1:0]    wb_cond,
  input  logic                          flush_valid,
  input  logic [ROBID_W-1:0]            flush_robid,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [DEPTH-1:0]              valid_out_array
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [COND_W-1:0] cond_q  [DEPTH];
  logic [COND_W-1:0] cond_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  rdy, win, enq_oh, kill, clr;
  logic              enq_fire, deq_fire, blocked, found;
  logic [CNT_W-1:0]  kill_cnt;

  // Channels applied in ascending order so a later channel wins on overlap.
  function automatic logic [COND_W-1:0] wake(
    input logic [COND_W-1:0]            c,
    input logic [ROBID_W-1:0]           rob,
    input logic [WB_PORTS-1:0]          v,
    input logic [WB_PORTS*ROBID_W-1:0]  r,
    input logic [WB_PORTS*COND_W-1:0]   m,
    input logic [WB_PORTS*COND_W-1:0]   wc
  );
    logic [COND_W-1:0] res;
    res = c;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (v[p] && r[p*ROBID_W +: ROBID_W] == rob)
        res = (res & ~m[p*COND_W +: COND_W]) | (wc[p*COND_W +: COND_W] & m[p*COND_W +: COND_W]);
    end
    return res;
  endfunction

  function automatic logic younger(input logic [ROBID_W-1:0] e, input logic [ROBID_W-1:0] f);
    if (e[ROBID_W-1] == f[ROBID_W-1]) return e[ROBID_W-2:0] > f[ROBID_W-2:0];
    else                              return e[ROBID_W-2:0] < f[ROBID_W-2:0];
  endfunction

  // Select and free-slot search, from registered state only.
  always_comb begin
    rdy       = '0;
    win       = '0;
    enq_oh    = '0;
    found     = 1'b0;
    blocked   = 1'b0;
    deq_data  = '0;
    deq_index = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      rdy[i] = valid_q[i] & (&cond_q[i]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++)
        if (rdy[j] && older_q[j][i]) blocked = 1'b1;
      win[i] = rdy[i] & ~blocked;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        enq_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
    enq_ready = ~(&valid_q) & ~flush_valid;
    deq_valid = (|rdy) & ~flush_valid;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (win[i] && deq_valid) begin
        deq_data  = data_q[i];
        deq_index = IDX_W'(i);
      end
    end
  end

  always_comb begin
    enq_fire = enq_valid & enq_ready;
    deq_fire = deq_valid & deq_ready;
    kill     = '0;
    kill_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill[i]  = flush_valid & valid_q[i] & younger(data_q[i][ROBID_LSB +: ROBID_W], flush_robid);
      kill_cnt = kill_cnt + CNT_W'(kill[i]);
    end
    clr = kill | (win & {DEPTH{deq_fire}});
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i] & ~clr[i];
      data_d[i]  = data_q[i];
      cond_d[i]  = wake(cond_q[i], data_q[i][ROBID_LSB +: ROBID_W],
                        wb_valid, wb_robid, wb_mask, wb_cond);
      older_d[i] = clr[i] ? '0 : (older_q[i] & ~clr);
    end
    // New entry is younger than every entry that survives this edge.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (enq_fire && enq_oh[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = enq_data;
        cond_d[k]  = wake(enq_condition, enq_data[ROBID_LSB +: ROBID_W],
                          wb_valid, wb_robid, wb_mask, wb_cond);
        older_d[k] = '0;
        for (int unsigned j = 0; j < DEPTH; j++)
          older_d[j][k] = valid_q[j] & ~clr[j];
      end
    end
    count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire) - kill_cnt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cond_q[i]  <= '0;
        data_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cond_q[i]  <= cond_d[i];
        data_q[i]  <= data_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  assign count           = count_q;
  assign valid_out_array = valid_q;

endmodule

// File: tb/tb_age_issue_queue_mwb.sv
// Directed bench for age_issue_queue_mwb at DEPTH=4.
module tb_age_issue_queue_mwb;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DATA_W = 248;
  localparam int unsigned COND_W = 2;
  localparam int unsigned ROBID_W = 7;
  localparam int unsigned ROBID_LSB = 241;
  localparam int unsigned WB_PORTS = 2;

  logic                         clock = 1'b0;
  logic                         reset_n = 1'b0;
  logic                         enq_valid = 1'b0;
  logic                         enq_ready;
  logic [DATA_W-1:0]            enq_data = '0;
  logic [COND_W-1:0]            enq_condition = '0;
  logic                         deq_valid;
  logic                         deq_ready = 1'b0;
  logic [DATA_W-1:0]            deq_data;
  logic [1:0]                   deq_index;
  logic [WB_PORTS-1:0]          wb_valid = '0;
  logic [WB_PORTS*ROBID_W-1:0]  wb_robid = '0;
  logic [WB_PORTS*COND_W-1:0]   wb_mask = '0;
  logic [WB_PORTS*COND_W-1:0]   wb_cond = '0;
  logic                         flush_valid = 1'b0;
  logic [ROBID_W-1:0]           flush_robid = '0;
  logic [2:0]                   count;
  logic [DEPTH-1:0]             valid_out_array;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  age_issue_queue_mwb #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .COND_W(COND_W), .ROBID_W(ROBID_W),
    .ROBID_LSB(ROBID_LSB), .WB_PORTS(WB_PORTS)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_condition(enq_condition),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .deq_index(deq_index),
    .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_mask(wb_mask), .wb_cond(wb_cond),
    .flush_valid(flush_valid), .flush_robid(flush_robid),
    .count(count), .valid_out_array(valid_out_array)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [ROBID_W-1:0] rob);
    logic [DATA_W-1:0] d;
    d = '0;
    d[ROBID_LSB +: ROBID_W] = rob;
    d[15:0] = {9'h0A5, rob};
    return d;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [ROBID_W-1:0] rob, input logic [COND_W-1:0] c);
    enq_valid = 1'b1;
    enq_data = mk(rob);
    enq_condition = c;
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    wb_valid = '0;
    flush_valid = 1'b0;
  endtask

  task automatic set_wb(input int unsigned p, input logic [ROBID_W-1:0] rob,
                        input logic [COND_W-1:0] m, input logic [COND_W-1:0] c);
    wb_valid[p] = 1'b1;
    wb_robid[p*ROBID_W +: ROBID_W] = rob;
    wb_mask[p*COND_W +: COND_W] = m;
    wb_cond[p*COND_W +: COND_W] = c;
  endtask

  task automatic do_reset();
    idle();
    deq_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #3;
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_data", deq_data, 0);
    check("rst_deq_index", deq_index, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_count", count, 0);
    reset_n = 1'b1;
    step();

    // 1: in-order issue of A,B,C
    enq(7'h01, 2'b11); #3; check("t1_empty_deq", deq_valid, 0); step();
    check("t1_cnt1", count, 1);
    enq(7'h02, 2'b11); step();
    check("t1_cnt2", count, 2);
    enq(7'h03, 2'b11); deq_ready = 1'b1; #3;
    check("t1_A", deq_data, mk(7'h01)); check("t1_A_idx", deq_index, 0);
    step(); check("t1_cnt3", count, 2);
    idle(); #3;
    check("t1_B", deq_data, mk(7'h02)); check("t1_B_idx", deq_index, 1);
    step(); check("t1_cnt4", count, 1);
    #3; check("t1_C", deq_data, mk(7'h03)); check("t1_C_idx", deq_index, 2);
    step(); check("t1_cnt5", count, 0); check("t1_empty", deq_valid, 0);

    // 2: younger ready entry bypasses older blocked one; wakeup releases A
    enq(7'h0A, 2'b00); step();
    enq(7'h0B, 2'b11); #3; check("t2_none_ready", deq_valid, 0); step();
    idle(); set_wb(0, 7'h0A, 2'b11, 2'b11); #3;
    check("t2_B_first", deq_data, mk(7'h0B)); check("t2_B_idx", deq_index, 1);
    step(); idle(); #3;
    check("t2_A_valid", deq_valid, 1); check("t2_A", deq_data, mk(7'h0A));
    step(); check("t2_cnt", count, 0);

    // 3: full queue refuses enqueue without overwrite
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq(7'(8'h14 + i), 2'b00); step();
    end
    check("t3_full_rdy", enq_ready, 0); check("t3_cnt", count, 4);
    enq(7'h1E, 2'b11); step();
    check("t3_hold_cnt", count, 4); check("t3_hold_valid", valid_out_array, 4'hF);
    check("t3_no_write", deq_valid, 0);
    idle(); set_wb(1, 7'h14, 2'b11, 2'b11); step(); idle(); #3;
    check("t3_slot0_kept", deq_data, mk(7'h14)); check("t3_slot0_idx", deq_index, 0);
    do_reset();

    // 4: flush across robid wrap
    enq(7'h7E, 2'b11); step();
    enq(7'h7F, 2'b00); step();
    enq(7'h00, 2'b00); step();
    enq(7'h01, 2'b00); step();
    idle(); #3; check("t4_pre_deq", deq_valid, 1);
    deq_ready = 1'b1; flush_valid = 1'b1; flush_robid = 7'h7F; #1;
    check("t4_flush_deq", deq_valid, 0); check("t4_flush_enq", enq_ready, 0);
    step(); idle();
    check("t4_cnt", count, 2); check("t4_valid", valid_out_array, 4'b0011);
    #3; check("t4_survivor", deq_data, mk(7'h7E));
    do_reset();

    // 5: enqueue-time wakeup bypass, then overlapping channels
    enq(7'h05, 2'b00); set_wb(0, 7'h05, 2'b01, 2'b01); set_wb(1, 7'h05, 2'b10, 2'b10);
    step(); idle(); deq_ready = 1'b1; #3;
    check("t5_byp_valid", deq_valid, 1); check("t5_byp_data", deq_data, mk(7'h05));
    step();
    enq(7'h06, 2'b10); set_wb(0, 7'h06, 2'b01, 2'b01); set_wb(1, 7'h06, 2'b01, 2'b00);
    step(); idle(); #3;
    check("t5_overlap", deq_valid, 0); check("t5_cnt", count, 1);
    set_wb(1, 7'h06, 2'b01, 2'b01); step(); idle(); #3;
    check("t5_woken", deq_data, mk(7'h06));
    do_reset();

    // 6: asynchronous reset with live entries
    for (int i = 0; i < 3; i++) begin
      enq(7'(8'h30 + i), 2'b11); step();
    end
    idle(); #1; check("t6_pre", deq_valid, 1);
    reset_n = 1'b0; #1;
    check("t6_deq", deq_valid, 0); check("t6_cnt", count, 0);
    check("t6_enq_rdy", enq_ready, 1); check("t6_valid", valid_out_array, 0);
    check("t6_data", deq_data, 0);
    #2; reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
